// File: rtl/multi_channel_bidir_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_bidir_buffer
// Brief    : NCH-channel bidirectional byte buffer; 2*NCH FIFOs share one
//            dual-port RAM, channel side time-multiplexed on port A.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_bidir_buffer #(
    parameter int NCH   = 2,
    parameter int SEL_W = 1,
    parameter int DW    = 8,
    parameter int AW    = 9,
    parameter int CW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH*DW-1:0] ch_dat_i,
    input  logic [NCH-1:0]    ch_wr_i,
    output logic [NCH*DW-1:0] ch_dat_o,
    input  logic [NCH-1:0]    ch_rd_i,
    output logic [NCH-1:0]    ch_empty_o,
    output logic [NCH-1:0]    ch_full_o,
    input  logic [NCH-1:0]    flush_i,
    input  logic [SEL_W-1:0]  Y_sel_i,
    input  logic [DW-1:0]     Y_dat_i,
    input  logic              Y_wr_i,
    output logic [DW-1:0]     Y_dat_o,
    input  logic              Y_rd_i,
    output logic              Y_empty_o,
    output logic              Y_full_o,
    output logic [CW-1:0]     Y_count_o
);

    localparam int          c_NF    = 2 * NCH;
    localparam int          c_FW    = $clog2(c_NF);
    localparam int          c_SLW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          c_RAW   = c_FW + AW;
    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};
    localparam int          c_CMAX  = (2 ** CW) - 1;

    // FIFO k (k < NCH) is channel k -> Y; FIFO NCH+k is Y -> channel k.
    logic [DW-1:0]    r_mem [c_NF * (2 ** AW)];
    logic [AW:0]      r_wr [c_NF];
    logic [AW:0]      r_rd [c_NF];
    logic [c_SLW-1:0] r_slot;
    logic [NCH-1:0]   r_hold_v;
    logic [DW-1:0]    r_hold_d [NCH];
    logic [NCH-1:0]   r_pf_v;
    logic [NCH-1:0]   r_pf_pend;
    logic [DW-1:0]    r_pa_q;

    logic [c_NF-1:0]  w_fifo_empty;
    logic [c_NF-1:0]  w_fifo_full;
    logic [NCH-1:0]   w_slot_hit;
    logic [NCH-1:0]   w_cap;
    logic [NCH-1:0]   w_commit;
    logic [NCH-1:0]   w_pf_issue;
    logic [NCH-1:0]   w_ch_rd;
    logic             w_pa_we;
    logic [c_RAW-1:0] w_pa_waddr;
    logic [c_RAW-1:0] w_pa_raddr;
    logic [DW-1:0]    w_pa_wdat;
    logic [NCH-1:0]   w_y_hit;
    logic             w_y_flush;
    logic             w_y_rd;
    logic             w_y_wr;
    logic [AW:0]      w_y_free;
    logic [CW-1:0]    w_y_cnt;
    logic [c_RAW-1:0] w_pb_raddr;
    logic [c_RAW-1:0] w_pb_waddr;

    always_comb begin
        for (int f = 0; f < c_NF; f++) begin
            w_fifo_empty[f] = (r_wr[f] == r_rd[f]);
            w_fifo_full[f]  = ((r_wr[f] - r_rd[f]) == c_DEPTH);
        end
    end

    // A held word always fits: only this channel fills its channel->Y FIFO.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_slot_hit[k] = (r_slot == c_SLW'(k));
            ch_full_o[k]  = w_fifo_full[k] | r_hold_v[k];
            ch_empty_o[k] = ~r_pf_v[k];
            w_cap[k]      = ch_wr_i[k] & ~ch_full_o[k] & ~flush_i[k];
            w_commit[k]   = w_slot_hit[k] & (r_hold_v[k] | w_cap[k]) & ~flush_i[k];
            w_pf_issue[k] = w_slot_hit[k] & ~w_fifo_empty[NCH+k] & ~r_pf_v[k]
                            & ~r_pf_pend[k] & ~flush_i[k];
            w_ch_rd[k]    = ch_rd_i[k] & r_pf_v[k] & ~flush_i[k];
        end
    end

    always_comb begin
        w_pa_we    = 1'b0;
        w_pa_waddr = '0;
        w_pa_raddr = '0;
        w_pa_wdat  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_slot_hit[k]) begin
                w_pa_we    = w_commit[k];
                w_pa_waddr = {c_FW'(k), r_wr[k][AW-1:0]};
                w_pa_raddr = {c_FW'(NCH + k), r_rd[NCH+k][AW-1:0]};
                w_pa_wdat  = r_hold_v[k] ? r_hold_d[k] : ch_dat_i[k*DW +: DW];
            end
        end
    end

    // An out-of-range select matches no channel and falls through the defaults.
    always_comb begin
        Y_empty_o  = 1'b1;
        Y_full_o   = 1'b1;
        w_y_hit    = '0;
        w_y_flush  = 1'b0;
        w_y_free   = '0;
        w_pb_raddr = '0;
        w_pb_waddr = '0;
        for (int k = 0; k < NCH; k++) begin
            if (Y_sel_i == SEL_W'(k)) begin
                w_y_hit[k] = 1'b1;
                Y_empty_o  = w_fifo_empty[k];
                Y_full_o   = w_fifo_full[NCH+k];
                w_y_flush  = flush_i[k];
                w_y_free   = c_DEPTH - (r_wr[NCH+k] - r_rd[NCH+k]);
                w_pb_raddr = {c_FW'(k), r_rd[k][AW-1:0]};
                w_pb_waddr = {c_FW'(NCH + k), r_wr[NCH+k][AW-1:0]};
            end
        end
        w_y_rd  = Y_rd_i & ~Y_empty_o & ~w_y_flush;
        w_y_wr  = Y_wr_i & ~Y_full_o & ~w_y_flush;
        w_y_cnt = (int'(w_y_free) > c_CMAX) ? CW'(c_CMAX) : CW'(w_y_free);
    end

    always_ff @(posedge clk_i) begin
        if (w_pa_we) r_mem[w_pa_waddr] <= w_pa_wdat;
        if (w_y_wr)  r_mem[w_pb_waddr] <= Y_dat_i;
        r_pa_q <= r_mem[w_pa_raddr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot    <= '0;
            r_hold_v  <= '0;
            r_pf_v    <= '0;
            r_pf_pend <= '0;
            ch_dat_o  <= '0;
            Y_dat_o   <= '0;
            Y_count_o <= '0;
            for (int f = 0; f < c_NF; f++) begin
                r_wr[f] <= '0;
                r_rd[f] <= '0;
            end
            for (int k = 0; k < NCH; k++) begin
                r_hold_d[k] <= '0;
            end
        end else begin
            r_slot    <= (r_slot == c_SLW'(NCH - 1)) ? '0 : r_slot + 1'b1;
            Y_count_o <= w_y_cnt;
            if (w_y_rd) Y_dat_o <= r_mem[w_pb_raddr];
            for (int k = 0; k < NCH; k++) begin
                if (flush_i[k]) begin
                    r_wr[k]       <= '0;
                    r_rd[k]       <= '0;
                    r_wr[NCH+k]   <= '0;
                    r_rd[NCH+k]   <= '0;
                    r_hold_v[k]   <= 1'b0;
                    r_pf_v[k]     <= 1'b0;
                    r_pf_pend[k]  <= 1'b0;
                end else begin
                    if (w_commit[k]) begin
                        r_wr[k]     <= r_wr[k] + 1'b1;
                        r_hold_v[k] <= 1'b0;
                    end else if (w_cap[k]) begin
                        r_hold_v[k] <= 1'b1;
                        r_hold_d[k] <= ch_dat_i[k*DW +: DW];
                    end
                    if (w_y_rd && w_y_hit[k]) r_rd[k]     <= r_rd[k] + 1'b1;
                    if (w_y_wr && w_y_hit[k]) r_wr[NCH+k] <= r_wr[NCH+k] + 1'b1;
                    if (w_pf_issue[k])        r_rd[NCH+k] <= r_rd[NCH+k] + 1'b1;
                    r_pf_pend[k] <= w_pf_issue[k];
                    // r_pa_q holds the word fetched in the slot cycle just ended.
                    if (r_pf_pend[k]) begin
                        ch_dat_o[k*DW +: DW] <= r_pa_q;
                        r_pf_v[k]            <= 1'b1;
                    end else if (w_ch_rd[k]) begin
                        r_pf_v[k] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
